// File: rtl/csa_serial_sub.sv
// Slice-serial subtractor: diff = a - b - bin, one 4-bit carry-select slice per clock,
// behind valid/ready operand and result handshakes.
module csa_serial_sub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);
    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_sh;     // minuend, shifted right one slice per CALC cycle
    logic [WIDTH-1:0] nb_sh;    // inverted subtrahend, shifted alongside a_sh
    logic [WIDTH-1:0] work;     // result slices enter at the top and shift down
    logic             carry;

    // Both carry hypotheses for the current slice, then the stored carry picks one.
    logic [4:0]       sum_c0;
    logic [4:0]       sum_c1;
    logic [4:0]       slice_sum;
    logic [WIDTH+3:0] work_ext;
    logic [WIDTH-1:0] work_next;
    logic             last_slice;

    always_comb begin
        sum_c0     = {1'b0, a_sh[3:0]} + {1'b0, nb_sh[3:0]};
        sum_c1     = {1'b0, a_sh[3:0]} + {1'b0, nb_sh[3:0]} + 5'd1;
        slice_sum  = carry ? sum_c1 : sum_c0;
        work_ext   = {slice_sum[3:0], work};
        work_next  = work_ext[WIDTH+3:4];
        last_slice = (k == KW'(N - 1));
    end

    assign in_ready = (state == IDLE) && !rst;

    // NOTE: only control and visible outputs are reset; the operand/working registers
    // are always reloaded at accept before use, so resetting them buys nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        nb_sh <= ~b;
                        carry <= ~bin;
                        k     <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    a_sh  <= a_sh >> 4;
                    nb_sh <= nb_sh >> 4;
                    work  <= work_next;
                    carry <= slice_sum[4];
                    k     <= k + KW'(1);
                    if (last_slice) begin
                        // At the last slice a_sh[3]/nb_sh[3] hold the operand sign bits.
                        diff      <= work_next;
                        bout      <= ~slice_sum[4];
                        ovf       <= (a_sh[3] == nb_sh[3]) && (work_next[WIDTH-1] != a_sh[3]);
                        out_valid <= 1'b1;
                        k         <= '0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_csa_serial_sub.sv
// Scoreboard bench for csa_serial_sub (WIDTH=16): directed vectors, backpressure,
// mid-operation reset.
module tb_csa_serial_sub;
    localparam int W = 16;
    localparam int N = W / 4;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } res_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int     n_vec  = 0;
    int     n_fail = 0;
    res_t   sb[$];
    logic [W-1:0] last_diff = '0;

    csa_serial_sub #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the result is consumed on the next rising edge whenever valid && ready.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'(diff), 32'hFFFF_FFFF);
            end else begin
                res_t e;
                e = sb.pop_front();
                check("sb_diff", 32'(diff), 32'(e.d));
                check("sb_bout", 32'(bout), 32'(e.bo));
                check("sb_ovf",  32'(ovf),  32'(e.ov));
            end
        end
    end

    task automatic wait_ready();
        int w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
    endtask

    // Issues one operation and checks latency plus result hold during CALC.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                        input logic [W-1:0] ed, input logic eb, input logic eo);
        res_t e;
        wait_ready();
        a = ta; b = tb_v; bin = tbin; in_valid = 1'b1;
        e.d = ed; e.bo = eb; e.ov = eo;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; bin = ~tbin;
        for (int i = 1; i <= N; i++) begin
            @(posedge clk); #1;
            check("latency_out_valid", 32'(out_valid), (i == N) ? 32'd1 : 32'd0);
            if (i < N) check("diff_hold", 32'(diff), 32'(last_diff));
        end
        last_diff = ed;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout_ovf", {30'd0, bout, ovf}, 32'd0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Directed vectors: a, b, bin -> diff, bout, ovf
        send(16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0);
        send(16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0);
        send(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        send(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        send(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
        send(16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        send(16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        send(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b0);
        @(posedge clk); #1;

        // Backpressure: result must hold, in_ready low, new in_valid ignored
        out_ready = 1'b0;
        send(16'h4321, 16'h1111, 1'b0, 16'h3210, 1'b0, 1'b0);
        a = 16'h0F0F; b = 16'h0101; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_diff", 32'(diff), 32'h3210);
            check("bp_bout_ovf", {30'd0, bout, ovf}, 32'd0);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("consume_out_valid", 32'(out_valid), 32'd0);
        check("consume_in_ready", 32'(in_ready), 32'd1);
        check("consume_diff_hold", 32'(diff), 32'h3210);
        send(16'h0100, 16'h0200, 1'b0, 16'hFF00, 1'b1, 1'b0);
        @(posedge clk); #1;

        // Reset on the 2nd CALC edge aborts the op; nothing is emitted
        wait_ready();
        a = 16'h0002; b = 16'h0003; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_diff", 32'(diff), 32'd0);
        check("midrst_bout_ovf", {30'd0, bout, ovf}, 32'd0);
        #1;
        check("midrst_in_ready_rel", 32'(in_ready), 32'd1);
        last_diff = '0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("no_stale_out_valid", 32'(out_valid), 32'd0);
        end
        send(16'hA5A5, 16'h5A5A, 1'b0, 16'h4B4B, 1'b0, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
